// File: rtl/r32i_pkg.sv
// +----------------------------------------------------------------------------+
// | r32i_pkg : shared types and constants for the RV32I fetch sequencer        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package r32i_pkg;

  localparam int                DATA_W     = 32;
  localparam int                INST_BYTES = 4;
  localparam logic [DATA_W-1:0] RESET_ADDR = 32'h0000_0000;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo_r32i.sv
// +----------------------------------------------------------------------------+
// | fetch_fifo_r32i : synchronous FIFO of fetched {pc, data} entries with flush |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_fifo_r32i
  import r32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  output logic                   valid,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  fetch_entry_t     r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  // Flush overrides both push and pop in the same cycle.
  assign w_do_push = push & ~flush;
  assign w_do_pop  = pop & ~flush & (r_count != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_entry;
  end

  assign valid = (r_count != '0);
  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_seq_r32i.sv
// +----------------------------------------------------------------------------+
// | fetch_seq_r32i : RV32I fetch sequencer - PC, imem request/response, buffer |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_seq_r32i #(
  parameter int                DATA_W     = r32i_pkg::DATA_W,
  parameter logic [DATA_W-1:0] RESET_ADDR = r32i_pkg::RESET_ADDR,
  parameter int                BUF_DEPTH  = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     imem_req_valid,
  output logic [DATA_W-1:0]        imem_req_addr,
  input  logic                     imem_req_ready,
  input  logic                     imem_rsp_valid,
  input  logic [DATA_W-1:0]        imem_rsp_data,
  output logic                     inst_valid,
  output logic [DATA_W-1:0]        inst_data,
  output logic [DATA_W-1:0]        inst_pc,
  input  logic                     inst_ready,
  input  logic                     redirect_valid,
  input  logic [DATA_W-1:0]        redirect_pc,
  input  logic signed [DATA_W-1:0] redirect_offset,
  input  logic                     halt,
  output logic                     align_fault
);

  import r32i_pkg::*;

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_t      r_state;
  fetch_state_t      w_state_next;
  logic [DATA_W-1:0] r_fetch_pc;
  logic [DATA_W-1:0] r_resp_pc;
  logic [CNT_W-1:0]  r_outstanding;
  logic [CNT_W-1:0]  r_drop;

  logic [DATA_W-1:0] w_target;
  logic              w_run;
  logic              w_credit_ok;
  logic              w_redirect_ok;
  logic              w_req_fire;
  logic              w_rsp_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic [CNT_W-1:0]  w_outstanding_next;
  logic              w_fifo_valid;
  logic [CNT_W-1:0]  w_fifo_count;
  fetch_entry_t      w_push_entry;
  fetch_entry_t      w_head;

  assign w_target      = redirect_pc + redirect_offset;
  assign w_run         = (r_state == RUN);
  assign w_credit_ok   = ({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < (CNT_W + 1)'(BUF_DEPTH);
  assign w_redirect_ok = w_run & redirect_valid & (w_target[1:0] == 2'b00);
  assign w_req_fire    = imem_req_valid & imem_req_ready;
  assign w_rsp_accept  = imem_rsp_valid & (r_outstanding != '0);
  assign w_pop         = inst_valid & inst_ready;
  assign w_push        = w_rsp_accept & (r_drop == '0) & w_run & ~redirect_valid;
  assign w_outstanding_next = r_outstanding + CNT_W'(w_req_fire) - CNT_W'(w_rsp_accept);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == RUN && redirect_valid && w_target[1:0] != 2'b00) w_state_next = FAULT;
  end

  // reset gates the request so every output reads 0 while reset is held.
  always_comb begin
    imem_req_valid = 1'b0;
    align_fault    = 1'b0;
    inst_valid     = 1'b0;
    w_flush        = 1'b0;
    case (r_state)
      RUN: begin
        imem_req_valid = ~reset & ~halt & w_credit_ok & ~redirect_valid;
        inst_valid     = w_fifo_valid;
        w_flush        = redirect_valid;
      end
      FAULT: begin
        align_fault = 1'b1;
        w_flush     = 1'b1;
      end
      default: ;
    endcase
  end

  // Everything still outstanding after a redirect belongs to the wrong path.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fetch_pc    <= RESET_ADDR;
      r_resp_pc     <= RESET_ADDR;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      if (w_redirect_ok) begin
        r_fetch_pc <= w_target;
        r_resp_pc  <= w_target;
        r_drop     <= w_outstanding_next;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + DATA_W'(INST_BYTES);
        if (w_push)     r_resp_pc  <= r_resp_pc + DATA_W'(INST_BYTES);
        if (w_rsp_accept && r_drop != '0) r_drop <= r_drop - 1'b1;
      end
    end
  end

  assign w_push_entry.pc   = r_resp_pc;
  assign w_push_entry.data = imem_rsp_data;

  fetch_fifo_r32i #(
    .DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (w_flush),
    .push      (w_push),
    .push_entry(w_push_entry),
    .pop       (w_pop),
    .valid     (w_fifo_valid),
    .head      (w_head),
    .count     (w_fifo_count)
  );

  assign imem_req_addr = r_fetch_pc;
  assign inst_data     = inst_valid ? w_head.data : '0;
  assign inst_pc       = inst_valid ? w_head.pc   : '0;

endmodule

`default_nettype wire

// File: tb/tb_fetch_seq_r32i.sv
// +----------------------------------------------------------------------------+
// | tb_fetch_seq_r32i : randomized bench for fetch_seq_r32i with a memory and  |
// | program-order reference model                                              |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_seq_r32i;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam int          BUF_DEPTH  = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready = 1'b1;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] redirect_offset = '0;
  logic        halt = 1'b0;
  logic        align_fault;

  fetch_seq_r32i #(
    .DATA_W    (32),
    .RESET_ADDR(RESET_ADDR),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (req_valid),
    .imem_req_addr  (req_addr),
    .imem_req_ready (req_ready),
    .imem_rsp_valid (rsp_valid),
    .imem_rsp_data  (rsp_data),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_offset(redirect_offset),
    .halt           (halt),
    .align_fault    (align_fault)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_fires = 0;
  int          n_pops = 0;
  int          stale = 0;
  int          mem_pct = 100;
  bit          mem_en = 1'b1;
  bit          model_fault = 1'b0;
  logic [31:0] exp_pc = RESET_ADDR;
  logic [31:0] fetch_ptr = RESET_ADDR;
  logic [31:0] last_fire_addr = '0;
  logic [31:0] m_tgt;
  logic [31:0] m_addr;
  logic [31:0] q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory model plus program-order reference: decode must see consecutive
  // PCs from the last taken target, each with the word stored at that PC.
  always @(negedge clock) begin
    if (reset) begin
      exp_pc      = RESET_ADDR;
      fetch_ptr   = RESET_ADDR;
      model_fault = 1'b0;
      stale       = q.size();
      rsp_valid   = 1'b0;
    end else begin
      if (model_fault) begin
        n_cmp++;
        if ({align_fault, req_valid, inst_valid} !== 3'b100) begin
          n_err++;
          $display("FAIL fault_outputs: got fault/req/inst=%b required 100", {align_fault, req_valid, inst_valid});
        end
      end else begin
        n_cmp++;
        if (align_fault !== 1'b0 || (req_valid && (halt || redirect_valid))) begin
          n_err++;
          $display("FAIL run_outputs: got fault=%b req=%b with halt=%b redir=%b", align_fault, req_valid, halt, redirect_valid);
        end
        if (req_valid && req_ready) begin
          n_cmp++;
          if (req_addr !== fetch_ptr) begin
            n_err++;
            $display("FAIL req_addr: got %h required %h", req_addr, fetch_ptr);
          end
          fetch_ptr      = fetch_ptr + 32'd4;
          last_fire_addr = req_addr;
          n_fires++;
        end
        if (inst_valid && inst_ready && !redirect_valid) begin
          n_cmp++;
          if (inst_pc !== exp_pc || inst_data !== mem_word(exp_pc)) begin
            n_err++;
            $display("FAIL inst_stream: got pc=%h data=%h required pc=%h data=%h", inst_pc, inst_data, exp_pc, mem_word(exp_pc));
          end
          exp_pc = exp_pc + 32'd4;
          n_pops++;
        end
        if (redirect_valid) begin
          m_tgt = redirect_pc + redirect_offset;
          if (m_tgt[1:0] != 2'b00) model_fault = 1'b1;
          else begin
            fetch_ptr = m_tgt;
            exp_pc    = m_tgt;
          end
        end
      end
      n_cmp++;
      if (q.size() - stale > BUF_DEPTH) begin
        n_err++;
        $display("FAIL credit: got %0d in flight required <= %0d", q.size() - stale, BUF_DEPTH);
      end
      rsp_valid = 1'b0;
      if (mem_en && q.size() > 0 && $urandom_range(0, 99) < mem_pct) begin
        m_addr    = q.pop_front();
        rsp_valid = 1'b1;
        rsp_data  = mem_word(m_addr);
        if (stale > 0) stale--;
      end
      if (req_valid && req_ready) q.push_back(req_addr);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    halt           = 1'b0;
    q.delete();
    tick(2);
    reset = 1'b0;
    #1;
  endtask

  task automatic wait_fires(input int target);
    int k = 0;
    while (n_fires < target && k < 40) begin
      tick(1);
      k++;
    end
    n_cmp++;
    if (n_fires < target) begin
      n_err++;
      $display("FAIL fire_timeout: got %0d fires required %0d", n_fires, target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    n_cmp++;
    if ({req_valid, inst_valid, align_fault} !== 3'b000 || req_addr !== 32'h0) begin
      n_err++;
      $display("FAIL reset_ctrl: got req/inst/fault=%b addr=%h required 000/0", {req_valid, inst_valid, align_fault}, req_addr);
    end
    n_cmp++;
    if (inst_data !== 32'h0 || inst_pc !== 32'h0) begin
      n_err++;
      $display("FAIL reset_data: got data=%h pc=%h required 0", inst_data, inst_pc);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (req_valid !== 1'b1 || req_addr !== RESET_ADDR) begin
      n_err++;
      $display("FAIL first_req: got valid=%b addr=%h required 1/%h", req_valid, req_addr, RESET_ADDR);
    end
  endtask

  task automatic test_stream();
    int p0;
    req_ready = 1'b1; mem_en = 1'b1; mem_pct = 100; inst_ready = 1'b1;
    do_reset();
    p0 = n_pops;
    tick(1);
    n_cmp++;
    if (inst_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stream_early: got inst_valid=%b required 0", inst_valid);
    end
    tick(1);
    n_cmp++;
    if (inst_valid !== 1'b1 || inst_pc !== RESET_ADDR) begin
      n_err++;
      $display("FAIL stream_first: got valid=%b pc=%h required 1/%h", inst_valid, inst_pc, RESET_ADDR);
    end
    tick(30);
    n_cmp++;
    if (n_pops - p0 < 15) begin
      n_err++;
      $display("FAIL stream_rate: got %0d pops required >= 15", n_pops - p0);
    end
  endtask

  task automatic test_backpressure();
    int f0;
    req_ready = 1'b1; mem_en = 1'b1; mem_pct = 100; inst_ready = 1'b0;
    do_reset();
    f0 = n_fires;
    tick(10);
    n_cmp++;
    if (n_fires - f0 != 2 || req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_full: got fires=%0d req=%b required 2/0", n_fires - f0, req_valid);
    end
    inst_ready = 1'b1;
    tick(1);
    inst_ready = 1'b0;
    tick(6);
    n_cmp++;
    if (n_fires - f0 != 3 || req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_refill: got fires=%0d req=%b required 3/0", n_fires - f0, req_valid);
    end
  endtask

  task automatic test_misaligned();
    int f0;
    req_ready = 1'b1; mem_en = 1'b0; inst_ready = 1'b0;
    do_reset();
    f0 = n_fires;
    wait_fires(f0 + 2);
    redirect_pc = 32'h8; redirect_offset = 32'd89; redirect_valid = 1'b1;
    tick(1);
    redirect_valid = 1'b0;
    mem_en = 1'b1;
    tick(5);
    n_cmp++;
    if ({align_fault, req_valid, inst_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL misaligned: got fault/req/inst=%b required 100", {align_fault, req_valid, inst_valid});
    end
  endtask

  task automatic test_redirect_back();
    int f0;
    int k;
    req_ready = 1'b1; mem_en = 1'b0; inst_ready = 1'b1; mem_pct = 100;
    do_reset();
    f0 = n_fires;
    wait_fires(f0 + 2);
    redirect_pc = 32'h10; redirect_offset = 32'hFFFF_FFF8; redirect_valid = 1'b1;
    #1;
    n_cmp++;
    if (req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL redir_noreq: got req_valid=%b required 0", req_valid);
    end
    tick(1);
    redirect_valid = 1'b0;
    mem_en = 1'b1;
    f0 = n_fires;
    wait_fires(f0 + 1);
    n_cmp++;
    if (last_fire_addr !== 32'h8) begin
      n_err++;
      $display("FAIL redir_addr: got %h required 00000008", last_fire_addr);
    end
    k = 0;
    while (inst_valid !== 1'b1 && k < 40) begin
      tick(1);
      k++;
    end
    n_cmp++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h8) begin
      n_err++;
      $display("FAIL redir_inst: got valid=%b pc=%h required 1/00000008", inst_valid, inst_pc);
    end
  endtask

  task automatic test_wrap();
    int f0;
    req_ready = 1'b0; mem_en = 1'b1; inst_ready = 1'b1;
    do_reset();
    redirect_pc = 32'h4; redirect_offset = 32'h7FFF_FFFC; redirect_valid = 1'b1;
    tick(1);
    redirect_valid = 1'b0;
    #1;
    n_cmp++;
    if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000) begin
      n_err++;
      $display("FAIL target_issue: got valid=%b addr=%h required 1/80000000", req_valid, req_addr);
    end
    redirect_pc = 32'hFFFF_FFF0; redirect_offset = 32'hC; redirect_valid = 1'b1;
    tick(1);
    redirect_valid = 1'b0;
    #1;
    n_cmp++;
    if (req_addr !== 32'hFFFF_FFFC) begin
      n_err++;
      $display("FAIL top_addr: got %h required fffffffc", req_addr);
    end
    f0 = n_fires;
    req_ready = 1'b1;
    wait_fires(f0 + 2);
    n_cmp++;
    if (last_fire_addr !== 32'h0) begin
      n_err++;
      $display("FAIL pc_wrap: got %h required 00000000", last_fire_addr);
    end
  endtask

  task automatic test_reset_inflight();
    int f0;
    int p0;
    req_ready = 1'b1; mem_en = 1'b0; inst_ready = 1'b1;
    do_reset();
    f0 = n_fires;
    wait_fires(f0 + 2);
    reset = 1'b1;
    tick(1);
    n_cmp++;
    if ({req_valid, inst_valid, align_fault} !== 3'b000) begin
      n_err++;
      $display("FAIL midreset: got req/inst/fault=%b required 000", {req_valid, inst_valid, align_fault});
    end
    req_ready = 1'b0;
    mem_en = 1'b1;
    tick(1);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (req_valid !== 1'b1 || req_addr !== RESET_ADDR) begin
      n_err++;
      $display("FAIL postreset_req: got valid=%b addr=%h required 1/%h", req_valid, req_addr, RESET_ADDR);
    end
    tick(4);
    n_cmp++;
    if (inst_valid !== 1'b0 || req_valid !== 1'b1) begin
      n_err++;
      $display("FAIL stale_rsp: got inst=%b req=%b required 0/1", inst_valid, req_valid);
    end
    p0 = n_pops;
    req_ready = 1'b1;
    tick(12);
    n_cmp++;
    if (n_pops - p0 < 4) begin
      n_err++;
      $display("FAIL postreset_flow: got %0d pops required >= 4", n_pops - p0);
    end
  endtask

  task automatic test_random();
    int p0;
    mem_en = 1'b1; mem_pct = 70;
    do_reset();
    p0 = n_pops;
    for (int i = 0; i < 3000; i++) begin
      req_ready       = ($urandom_range(0, 3) != 0);
      inst_ready      = ($urandom_range(0, 2) != 0);
      halt            = ($urandom_range(0, 9) == 0);
      redirect_valid  = ($urandom_range(0, 29) == 0);
      redirect_pc     = $urandom & 32'hFFFF_FFFC;
      redirect_offset = 32'($urandom_range(0, 64)) * 32'd4 - 32'd128;
      if ($urandom_range(0, 499) == 0) do_reset();
      else tick(1);
    end
    redirect_valid = 1'b0; halt = 1'b0; inst_ready = 1'b1; req_ready = 1'b1;
    tick(20);
    n_cmp++;
    if (n_pops - p0 < 200) begin
      n_err++;
      $display("FAIL random_progress: got %0d pops required >= 200", n_pops - p0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_misaligned();
    test_redirect_back();
    test_wrap();
    test_reset_inflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
